// File: rtl/vx_mem_responder_if.sv
// Line-granular memory bus between a cache memory arbiter (master) and a
// backing-memory responder (slave).
interface vx_mem_responder_if #(
  parameter int LINE_SIZE  = 64,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8
);
  logic                   mem_req_valid;
  logic                   mem_req_rw;
  logic [ADDR_WIDTH-1:0]  mem_req_addr;
  logic [LINE_SIZE-1:0]   mem_req_byteen;
  logic [LINE_SIZE*8-1:0] mem_req_data;
  logic [TAG_WIDTH-1:0]   mem_req_tag;
  logic                   mem_req_ready;

  logic                   mem_rsp_valid;
  logic [LINE_SIZE*8-1:0] mem_rsp_data;
  logic [TAG_WIDTH-1:0]   mem_rsp_tag;
  logic                   mem_rsp_ready;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/vx_mem_responder.sv
// Byte-enabled line memory answering reads in order after a fixed latency.
// Optional performance counters are enabled by defining VX_MEM_RESPONDER_PERF_EN.
module vx_mem_responder #(
  parameter int LINE_SIZE      = 64,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = 8,
  parameter int DEPTH          = 1024,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE_SIZE = 4
) (
  input  logic               clk,
  input  logic               reset,
  vx_mem_responder_if.slave  mem_bus
`ifdef VX_MEM_RESPONDER_PERF_EN
  ,
  output logic [31:0]        perf_reads,
  output logic [31:0]        perf_writes,
  output logic [31:0]        perf_stalls,
  output logic [31:0]        perf_rsp_stalls
`endif
);
  localparam int DATA_W = LINE_SIZE * 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(RSP_QUEUE_SIZE + 1);
  localparam int PTR_W  = (RSP_QUEUE_SIZE > 1) ? $clog2(RSP_QUEUE_SIZE) : 1;

  logic [DATA_W-1:0]    mem_array [DEPTH];
  logic [DATA_W-1:0]    rd_data_reg;
  logic [IDX_W-1:0]     req_idx;
  logic [CNT_W-1:0]     outstanding_reg;
  logic                 req_ready, read_fire, write_fire;

  logic                 pipe_valid_reg [LATENCY];
  logic [TAG_WIDTH-1:0] pipe_tag_reg   [LATENCY];
  logic [DATA_W-1:0]    pipe_out_data;
  logic                 pipe_out_valid;

  logic [DATA_W-1:0]    q_data_reg [RSP_QUEUE_SIZE];
  logic [TAG_WIDTH-1:0] q_tag_reg  [RSP_QUEUE_SIZE];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     q_count_reg;
  logic                 q_empty, rsp_valid, rsp_pop, push_store, pop_from_q;

  assign req_idx    = mem_bus.mem_req_addr[IDX_W-1:0];
  assign req_ready  = !reset && (outstanding_reg < CNT_W'(RSP_QUEUE_SIZE));
  assign read_fire  = mem_bus.mem_req_valid && req_ready && !mem_bus.mem_req_rw;
  assign write_fire = mem_bus.mem_req_valid && req_ready && mem_bus.mem_req_rw;
  assign mem_bus.mem_req_ready = req_ready;

  // Upper address bits only alias onto the same line.
  generate
    if (ADDR_WIDTH > IDX_W) begin : g_addr_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^mem_bus.mem_req_addr[ADDR_WIDTH-1:IDX_W];
    end
  endgenerate

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_QUEUE_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (write_fire) begin
      for (int b = 0; b < LINE_SIZE; b++) begin
        if (mem_bus.mem_req_byteen[b])
          mem_array[req_idx][b*8 +: 8] <= mem_bus.mem_req_data[b*8 +: 8];
      end
    end
    rd_data_reg <= mem_array[req_idx];
  end

  // rd_data_reg is the first data stage; the rest shift behind it.
  generate
    if (LATENCY > 1) begin : g_data_sr
      logic [DATA_W-1:0] data_sr_reg [LATENCY-1];
      always_ff @(posedge clk) begin
        data_sr_reg[0] <= rd_data_reg;
        for (int i = 1; i < LATENCY - 1; i++)
          data_sr_reg[i] <= data_sr_reg[i-1];
      end
      assign pipe_out_data = data_sr_reg[LATENCY-2];
    end else begin : g_data_direct
      assign pipe_out_data = rd_data_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    pipe_tag_reg[0] <= mem_bus.mem_req_tag;
    for (int i = 1; i < LATENCY; i++)
      pipe_tag_reg[i] <= pipe_tag_reg[i-1];
    if (reset) begin
      for (int i = 0; i < LATENCY; i++)
        pipe_valid_reg[i] <= 1'b0;
    end else begin
      pipe_valid_reg[0] <= read_fire;
      for (int i = 1; i < LATENCY; i++)
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
    end
  end

  assign pipe_out_valid = pipe_valid_reg[LATENCY-1];

  // Fall-through: an empty queue presents the pipeline exit directly and
  // only stores it when the consumer does not take it the same cycle.
  assign q_empty    = (q_count_reg == '0);
  assign rsp_valid  = !reset && (!q_empty || pipe_out_valid);
  assign rsp_pop    = rsp_valid && mem_bus.mem_rsp_ready;
  assign push_store = pipe_out_valid && !(q_empty && rsp_pop);
  assign pop_from_q = rsp_pop && !q_empty;

  assign mem_bus.mem_rsp_valid = rsp_valid;
  assign mem_bus.mem_rsp_data  = !rsp_valid ? '0 : (q_empty ? pipe_out_data : q_data_reg[rd_ptr_reg]);
  assign mem_bus.mem_rsp_tag   = !rsp_valid ? '0 : (q_empty ? pipe_tag_reg[LATENCY-1] : q_tag_reg[rd_ptr_reg]);

  always_ff @(posedge clk) begin
    if (push_store) begin
      q_data_reg[wr_ptr_reg] <= pipe_out_data;
      q_tag_reg[wr_ptr_reg]  <= pipe_tag_reg[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      q_count_reg     <= '0;
      outstanding_reg <= '0;
    end else begin
      if (push_store) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_from_q) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push_store, pop_from_q})
        2'b10:   q_count_reg <= q_count_reg + 1'b1;
        2'b01:   q_count_reg <= q_count_reg - 1'b1;
        default: q_count_reg <= q_count_reg;
      endcase
      case ({read_fire, rsp_pop})
        2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
        2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

`ifdef VX_MEM_RESPONDER_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads      <= '0;
      perf_writes     <= '0;
      perf_stalls     <= '0;
      perf_rsp_stalls <= '0;
    end else begin
      if (read_fire)  perf_reads  <= perf_reads + 32'd1;
      if (write_fire) perf_writes <= perf_writes + 32'd1;
      if (mem_bus.mem_req_valid && !req_ready)     perf_stalls     <= perf_stalls + 32'd1;
      if (rsp_valid && !mem_bus.mem_rsp_ready)     perf_rsp_stalls <= perf_rsp_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vx_mem_responder.sv
// Self-checking bench for vx_mem_responder: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_vx_mem_responder;
  localparam int LS    = 64;
  localparam int DW    = LS * 8;
  localparam int AW    = 26;
  localparam int TW    = 8;
  localparam int DEPTH = 16;
  localparam int LAT   = 4;
  localparam int Q     = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_mem_responder_if #(.LINE_SIZE(LS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

`ifdef VX_MEM_RESPONDER_PERF_EN
  logic [31:0] perf_reads, perf_writes, perf_stalls, perf_rsp_stalls;
`endif

  vx_mem_responder #(
    .LINE_SIZE(LS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .DEPTH(DEPTH), .LATENCY(LAT), .RSP_QUEUE_SIZE(Q)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .mem_bus (bus)
`ifdef VX_MEM_RESPONDER_PERF_EN
    ,
    .perf_reads      (perf_reads),
    .perf_writes     (perf_writes),
    .perf_stalls     (perf_stalls),
    .perf_rsp_stalls (perf_rsp_stalls)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a byte memory plus a list of reads not yet answered.
  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            due;
  } exp_t;

  logic [7:0]    model_mem [DEPTH][LS];
  exp_t          exp_q [$];

  int            fire_cyc [$];
  logic [TW-1:0] fire_tag [$];
  int            pop_cyc  [$];
  logic [TW-1:0] pop_tag  [$];
  logic [DW-1:0] pop_data [$];

  function automatic logic [DW-1:0] model_line(input int idx);
    logic [DW-1:0] l;
    for (int b = 0; b < LS; b++) l[b*8 +: 8] = model_mem[idx][b];
    return l;
  endfunction

  always @(negedge clk) begin : monitor
    logic exp_ready, exp_valid;
    int   idx;
    exp_t e;
    cyc++;
    exp_ready = !reset && (exp_q.size() < Q);
    exp_valid = !reset && (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    check("req_ready", DW'(bus.mem_req_ready), DW'(exp_ready));
    check("rsp_valid", DW'(bus.mem_rsp_valid), DW'(exp_valid));
    if (reset) check("rsp_data_in_reset", bus.mem_rsp_data, '0);
    if (exp_valid) begin
      check("rsp_data", bus.mem_rsp_data, exp_q[0].data);
      check("rsp_tag", DW'(bus.mem_rsp_tag), DW'(exp_q[0].tag));
    end
    if (bus.mem_rsp_valid && bus.mem_rsp_ready) begin
      pop_cyc.push_back(cyc);
      pop_tag.push_back(bus.mem_rsp_tag);
      pop_data.push_back(bus.mem_rsp_data);
      $display("rsp cyc=%0d tag=%02h data_lo=%016h", cyc, bus.mem_rsp_tag, bus.mem_rsp_data[63:0]);
    end
    if (reset) begin
      exp_q.delete();
    end else begin
      if (exp_valid && bus.mem_rsp_ready) void'(exp_q.pop_front());
      if (bus.mem_req_valid && exp_ready) begin
        idx = int'(bus.mem_req_addr % DEPTH);
        if (bus.mem_req_rw) begin
          for (int b = 0; b < LS; b++)
            if (bus.mem_req_byteen[b]) model_mem[idx][b] = bus.mem_req_data[b*8 +: 8];
          $display("wr  cyc=%0d addr=%0d byteen=%016h", cyc, bus.mem_req_addr, bus.mem_req_byteen);
        end else begin
          e.data = model_line(idx);
          e.tag  = bus.mem_req_tag;
          e.due  = cyc + LAT;
          exp_q.push_back(e);
          fire_cyc.push_back(cyc);
          fire_tag.push_back(bus.mem_req_tag);
          $display("rd  cyc=%0d addr=%0d tag=%02h", cyc, bus.mem_req_addr, bus.mem_req_tag);
        end
      end
    end
  end

  task automatic clear_logs();
    fire_cyc.delete(); fire_tag.delete();
    pop_cyc.delete();  pop_tag.delete(); pop_data.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request until accepted (bounded), then drops valid.
  task automatic do_req(input logic rw, input logic [AW-1:0] addr, input logic [LS-1:0] be,
                        input logic [DW-1:0] data, input logic [TW-1:0] tag, output int waits);
    bus.mem_req_valid  = 1'b1;
    bus.mem_req_rw     = rw;
    bus.mem_req_addr   = addr;
    bus.mem_req_byteen = be;
    bus.mem_req_data   = data;
    bus.mem_req_tag    = tag;
    waits = 0;
    @(negedge clk);
    while (!bus.mem_req_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    check("req_accept", DW'(bus.mem_req_ready), DW'(1'b1));
    @(posedge clk);
    #1;
    bus.mem_req_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    logic [DW-1:0] d, exp_line;
    int w, stalls;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_rw     = 1'b0;
    bus.mem_req_addr   = '0;
    bus.mem_req_byteen = '0;
    bus.mem_req_data   = '0;
    bus.mem_req_tag    = '0;
    bus.mem_rsp_ready  = 1'b1;

    idle(3);
    reset = 1'b0;
    check("outstanding_after_reset", DW'(dut.outstanding_reg), '0);

    // Preload every line with a known pattern.
    for (int i = 0; i < DEPTH; i++) begin
      for (int b = 0; b < LS; b++) d[b*8 +: 8] = 8'(i * 16 + b);
      do_req(1'b1, AW'(i), '1, d, '0, w);
    end

    // Full-line write then read.
    clear_logs();
    d = {64{8'hA5}};
    do_req(1'b1, AW'(5), '1, d, '0, w);
    do_req(1'b0, AW'(5), '0, '0, 8'h3C, w);
    idle(8);
    exp_line = {64{8'hA5}};
    check("t1_count", DW'(pop_cyc.size()), DW'(1));
    if (pop_cyc.size() == 1 && fire_cyc.size() == 1) begin
      check("t1_latency", DW'(pop_cyc[0] - fire_cyc[0]), DW'(4));
      check("t1_data", pop_data[0], exp_line);
      check("t1_tag", DW'(pop_tag[0]), DW'(8'h3C));
    end

    // Byte masking.
    clear_logs();
    d = {64{8'h11}};
    do_req(1'b1, AW'(7), '1, d, '0, w);
    d = {64{8'h22}};
    do_req(1'b1, AW'(7), LS'(1), d, '0, w);
    do_req(1'b0, AW'(7), '0, '0, 8'h01, w);
    idle(8);
    exp_line = {{63{8'h11}}, 8'h22};
    check("t2_count", DW'(pop_cyc.size()), DW'(1));
    if (pop_data.size() == 1) check("t2_data", pop_data[0], exp_line);

    // Backpressure: fill all credits, hold one more request.
    clear_logs();
    bus.mem_rsp_ready = 1'b0;
    for (int t = 0; t < Q; t++) do_req(1'b0, AW'(t), '0, '0, TW'(t), w);
    bus.mem_req_valid = 1'b1;
    bus.mem_req_rw    = 1'b0;
    bus.mem_req_addr  = AW'(9);
    bus.mem_req_tag   = TW'(Q);
    repeat (3) begin
      @(negedge clk);
      check("t3_ready_low", DW'(bus.mem_req_ready), DW'(1'b0));
    end
    check("t3_held", DW'(fire_cyc.size()), DW'(Q));
    @(posedge clk); #1;
    bus.mem_rsp_ready = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.mem_req_ready && w < 50) begin w++; @(negedge clk); end
    check("t3_accept", DW'(bus.mem_req_ready), DW'(1'b1));
    @(posedge clk); #1;
    bus.mem_req_valid = 1'b0;
    idle(15);
    check("t3_count", DW'(pop_tag.size()), DW'(Q + 1));
    for (int k = 0; k < pop_tag.size(); k++) check("t3_order", DW'(pop_tag[k]), DW'(k));
    if (fire_cyc.size() == Q + 1 && pop_cyc.size() > 0)
      check("t3_accept_after_pop", DW'(fire_cyc[Q] - pop_cyc[0]), DW'(1));

    // Streaming: 32 back-to-back reads.
    clear_logs();
    stalls = 0;
    for (int i = 0; i < 32; i++) begin
      do_req(1'b0, AW'(i % DEPTH), '0, '0, TW'(8'h40 + i), w);
      stalls += w;
    end
    idle(10);
    check("t4_no_stall", DW'(stalls), DW'(0));
    check("t4_count", DW'(pop_cyc.size()), DW'(32));
    if (pop_cyc.size() == 32 && fire_cyc.size() == 32) begin
      check("t4_first", DW'(pop_cyc[0] - fire_cyc[0]), DW'(4));
      check("t4_fire_span", DW'(fire_cyc[31] - fire_cyc[0]), DW'(31));
      check("t4_rsp_span", DW'(pop_cyc[31] - pop_cyc[0]), DW'(31));
      check("t4_last_tag", DW'(pop_tag[31]), DW'(8'h5F));
    end

    // Aliasing: DEPTH+3 and 3 are the same line.
    clear_logs();
    d = {32{16'hBEEF}};
    do_req(1'b1, AW'(DEPTH + 3), '1, d, '0, w);
    do_req(1'b0, AW'(3), '0, '0, 8'h77, w);
    idle(8);
    exp_line = {32{16'hBEEF}};
    check("t5_count", DW'(pop_cyc.size()), DW'(1));
    if (pop_data.size() == 1) check("t5_data", pop_data[0], exp_line);

    // Reset with reads in flight.
    clear_logs();
    bus.mem_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_req(1'b0, AW'(i), '0, '0, TW'(8'h90 + i), w);
    idle(2);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    check("t6_ready_after_reset", DW'(bus.mem_req_ready), DW'(1'b1));
    check("t6_outstanding", DW'(dut.outstanding_reg), '0);
    @(posedge clk); #1;
    bus.mem_rsp_ready = 1'b1;
    idle(10);
    check("t6_no_rsp", DW'(pop_cyc.size()), DW'(0));
    check("t6_fired", DW'(fire_cyc.size()), DW'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
